truth_table_sweep: RTL and testbench
====================================

Name: truth_table_sweep

Overview:
- Stimulus/capture stage wrapped around a 3-input combinational truth-table gate.
- Upstream: drives in1/in2/in3 through all 8 input rows.
- Downstream: samples the gate's `out` after a settle window and assembles the measured 8-bit truth table.
- Compares the measured table with an expected hex code. Row 000 maps to bit 7 and row 111 to bit 0, so gate 0x2B yields 8'h2B.

Parameters:
- SETTLE, 4, cycles each input row is held before `out` is sampled; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; accepted only in IDLE.
- abort  input  1  cancel a sweep in progress.
- expected  input  8  expected truth table; row 000 = bit 7.
- dut_out  input  1  gate output being measured.
- in1  output  1  gate input MSB.
- in2  output  1  gate input middle bit.
- in3  output  1  gate input LSB.
- busy  output  1  high while a sweep is active.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  measured == expected; valid from done, held until next start.
- table_out  output  8  measured table; valid from done, held until next start.

Behaviour:
- Reset (async assert, any state): state=IDLE; in1..in3=0; busy=0; done=0; pass=0; table_out=8'h00; row=0; settle counter=0.
- States: IDLE, SETTLE, FINISH.
- IDLE:
  - start=1 at edge k -> SETTLE; row=0; counter=0; busy=1 from cycle k+1.
  - {in1,in2,in3}=row is registered, so it is driven from k+1.
  - Internal capture register cleared.
  - table_out and pass keep their previous values until the first capture.
- SETTLE:
  - {in1,in2,in3}=row[2:0]; counter increments each cycle.
  - When counter==SETTLE-1: capture dut_out into table bit (7-row) and reset counter to 0.
  - If row==7, go to FINISH; otherwise row increments.
  - Each row is held exactly SETTLE cycles. dut_out is sampled in the last cycle of the window.
- FINISH (one cycle):
  - done=1; busy=0.
  - table_out=captured table; pass=(captured table==expected).
  - expected is sampled this cycle.
  - Next state IDLE; in1..in3 return to 000.
- Latency: start accepted at edge k -> done high in cycle k+8*SETTLE+1. Total busy cycles = 8*SETTLE.
- start while busy or in FINISH: ignored, no restart.
- abort=1 in SETTLE:
  - Next cycle: IDLE, busy=0, in1..in3=000, no done.
  - table_out and pass unchanged.
- abort in IDLE or FINISH: no effect; FINISH still completes.
- abort and start together in IDLE: start wins.
- SETTLE=1: one cycle per row; the capture happens in the same cycle the row is first driven.
- Counter width: 8 bits. Row counter: 3 bits, no wrap beyond 7 since FINISH is taken.

Optional Feature:
- Macro TRUTH_TABLE_SWEEP_MISMATCH_EN.
- Defined:
  - Adds output port mismatch_mask [7:0] = captured ^ expected, registered in FINISH with the same hold rules as table_out; reset value 8'h00.
  - Adds output first_bad [2:0] = lowest row index (row 000 first) with a mismatch; 3'd0 when none; reset value 0.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Pass case: SETTLE=4, bench models the 0x2B gate, expected=8'h2B, pulse start -> in rows 000..111 each held 4 cycles; done at start+33; table_out=8'h2B; pass=1.
- Fail case: expected=8'h2A against the 0x2B model -> table_out=8'h2B, pass=0. With macro: mismatch_mask=8'h01, first_bad=3'd7.
- Settle sensitivity: bench gate output lags its inputs by 3 cycles, SETTLE=4 -> table_out=8'h2B. With SETTLE=2 -> table_out != 8'h2B.
- Abort: abort at 10 cycles after start -> busy low next cycle; in=000; no done pulse; table_out retains the previous sweep's value.
- Reset mid-sweep: assert rst asynchronously in row 5 -> all outputs 0 immediately; a subsequent start runs a full 8-row sweep from row 000.
- Ignored start: re-pulse start during row 3 and again in the FINISH cycle -> single done; total busy 32 cycles; no restart.

Source files
------------

// File: rtl/truth_table_sweep.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweep
// Description : Drives a 3-input combinational gate through all 8 input rows,
//               samples its output after a SETTLE-cycle window per row, and
//               compares the measured truth table with an expected code.
//               Row 000 lands in table bit 7, row 111 in bit 0.
//               Optional macro TRUTH_TABLE_SWEEP_MISMATCH_EN adds the
//               mismatch_mask and first_bad diagnostic outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweep #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out
`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
  ,
  output logic [7:0] mismatch_mask,
  output logic [2:0] first_bad
`endif
);

  // Counter value marking the last cycle of a row's settle window.
  localparam logic [7:0] c_last_cnt = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_row;
  logic [7:0] r_cnt;
  logic [7:0] r_cap;
  logic [7:0] r_table;
  logic [2:0] r_in;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       w_last;
  logic [7:0] w_cap_next;
  logic [7:0] w_cmp_src;
  logic [7:0] w_mask;
  logic       w_match;

  assign in1       = r_in[2];
  assign in2       = r_in[1];
  assign in3       = r_in[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign table_out = r_table;

  assign w_last = (r_cnt == c_last_cnt);

  // Capture register with the current row's sample merged in.
  always_comb begin
    w_cap_next = r_cap;
    w_cap_next[3'd7 - r_row] = dut_out;
  end

  // The comparison source is the freshly completed table when entering FINISH
  // and the published table while in FINISH, where expected is re-sampled.
  always_comb begin
    w_cmp_src = (r_state == S_FINISH) ? r_table : w_cap_next;
    w_mask    = w_cmp_src ^ expected;
    w_match   = (w_mask == 8'h00);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; start beats abort in IDLE since abort is ignored there.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: begin
        if (abort)                          w_next = S_IDLE;
        else if (w_last && r_row == 3'd7)   w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Row sequencing, settle timing, capture and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= 3'd0;
      r_cnt   <= 8'd0;
      r_cap   <= 8'h00;
      r_table <= 8'h00;
      r_in    <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_row  <= 3'd0;
            r_cnt  <= 8'd0;
            r_cap  <= 8'h00;
            r_in   <= 3'd0;
            r_busy <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_row  <= 3'd0;
            r_cnt  <= 8'd0;
            r_in   <= 3'd0;
            r_busy <= 1'b0;
          end else if (w_last) begin
            r_cnt <= 8'd0;
            r_cap <= w_cap_next;
            if (r_row == 3'd7) begin
              // Publish on entry so results are valid alongside done.
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_in    <= 3'd0;
              r_table <= w_cap_next;
              r_pass  <= w_match;
            end else begin
              r_row <= r_row + 3'd1;
              r_in  <= r_row + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_FINISH: begin
          r_done <= 1'b0;
          r_pass <= w_match;
          r_row  <= 3'd0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
  logic [7:0] r_mask;
  logic [2:0] r_first;
  logic [2:0] w_first;

  assign mismatch_mask = r_mask;
  assign first_bad     = r_first;

  // Lowest mismatching row is the highest set mask bit; scan upward so it wins.
  always_comb begin
    w_first = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (w_mask[b]) w_first = 3'(7 - b);
    end
  end

  // Diagnostic registers follow the same publish/hold timing as pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask  <= 8'h00;
      r_first <= 3'd0;
    end else if ((r_state == S_SETTLE && !abort && w_last && r_row == 3'd7) ||
                 (r_state == S_FINISH)) begin
      r_mask  <= w_mask;
      r_first <= w_first;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweep
// Description : Directed self-checking bench for truth_table_sweep. Instance A
//               uses SETTLE=4, instance B uses SETTLE=2; both measure a 0x2B
//               gate model that can optionally lag its inputs by 3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweep;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, abort_a = 1'b0;
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [7:0] expected_a = 8'h2B, expected_b = 8'h2B;
  logic       out_a, out_b;
  logic       in1_a, in2_a, in3_a, busy_a, done_a, pass_a;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, pass_b;
  logic [7:0] table_a, table_b;
`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
  logic [7:0] mask_a, mask_b;
  logic [2:0] fbad_a, fbad_b;
`endif

  logic [7:0] tt = 8'h2B;
  logic       lag = 1'b0;
  logic [2:0] da1 = 3'd0, da2 = 3'd0, da3 = 3'd0;
  logic [2:0] db1 = 3'd0, db2 = 3'd0, db3 = 3'd0;
  logic [2:0] idx_a, idx_b;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_sweep #(.SETTLE(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .expected(expected_a), .dut_out(out_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .table_out(table_a)
`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
    , .mismatch_mask(mask_a), .first_bad(fbad_a)
`endif
  );

  truth_table_sweep #(.SETTLE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .expected(expected_b), .dut_out(out_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .table_out(table_b)
`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
    , .mismatch_mask(mask_b), .first_bad(fbad_b)
`endif
  );

  // Three-cycle input delay lines for the lagging gate model.
  always @(posedge clk) begin
    da1 <= {in1_a, in2_a, in3_a}; da2 <= da1; da3 <= da2;
    db1 <= {in1_b, in2_b, in3_b}; db2 <= db1; db3 <= db2;
  end

  // Gate model: row r produces truth-table bit (7-r).
  always_comb begin
    idx_a = lag ? da3 : {in1_a, in2_a, in3_a};
    idx_b = lag ? db3 : {in1_b, in2_b, in3_b};
    out_a = tt[3'd7 - idx_a];
    out_b = tt[3'd7 - idx_b];
  end

  // Start pulse on A; returns at the sampling point of the first busy cycle.
  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy_a, done_a, pass_a, in1_a, in2_a, in3_a} !== 6'b0 || table_a !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b in=%b%b%b table=%h, want all zero",
               busy_a, done_a, pass_a, in1_a, in2_a, in3_a, table_a);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass();
    expected_a = 8'h2B;
    pulse_start_a();
    for (int j = 1; j <= 32; j++) begin
      n_checks++;
      if (busy_a !== 1'b1 || done_a !== 1'b0 || {in1_a, in2_a, in3_a} !== 3'((j - 1) / 4)) begin
        n_fail++;
        $display("FAIL pass_row cycle %0d: busy=%b done=%b in=%b%b%b, want busy=1 done=0 in=%0d",
                 j, busy_a, done_a, in1_a, in2_a, in3_a, (j - 1) / 4);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || table_a !== 8'h2B || pass_a !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_done: done=%b busy=%b table=%h pass=%b, want 1 0 2b 1",
               done_a, busy_a, table_a, pass_a);
    end
`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
    n_checks++;
    if (mask_a !== 8'h00 || fbad_a !== 3'd0) begin
      n_fail++;
      $display("FAIL pass_mask: mask=%h first_bad=%0d, want 00 0", mask_a, fbad_a);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b0 || table_a !== 8'h2B || pass_a !== 1'b1 || {in1_a, in2_a, in3_a} !== 3'd0) begin
      n_fail++;
      $display("FAIL pass_hold: done=%b table=%h pass=%b in=%b%b%b, want 0 2b 1 000",
               done_a, table_a, pass_a, in1_a, in2_a, in3_a);
    end
  endtask

  task automatic test_fail();
    expected_a = 8'h2A;
    pulse_start_a();
    repeat (32) @(negedge clk);
    n_checks++;
    if (done_a !== 1'b1 || table_a !== 8'h2B || pass_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_done: done=%b table=%h pass=%b, want 1 2b 0", done_a, table_a, pass_a);
    end
`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
    n_checks++;
    if (mask_a !== 8'h01 || fbad_a !== 3'd7) begin
      n_fail++;
      $display("FAIL fail_mask: mask=%h first_bad=%0d, want 01 7", mask_a, fbad_a);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (pass_a !== 1'b0 || table_a !== 8'h2B) begin
      n_fail++;
      $display("FAIL fail_hold: pass=%b table=%h, want 0 2b", pass_a, table_a);
    end
  endtask

  task automatic test_settle();
    lag = 1'b1;
    expected_a = 8'h2B;
    expected_b = 8'h2B;
    repeat (4) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (16) @(negedge clk);
    n_checks++;
    // Each 2-cycle window sees the previous row through the 3-cycle lag.
    if (done_b !== 1'b1 || table_b !== 8'h15 || pass_b !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_short: done=%b table=%h pass=%b, want 1 15 0", done_b, table_b, pass_b);
    end
    repeat (4) @(negedge clk);
    pulse_start_a();
    repeat (32) @(negedge clk);
    n_checks++;
    if (done_a !== 1'b1 || table_a !== 8'h2B || pass_a !== 1'b1) begin
      n_fail++;
      $display("FAIL settle_long: done=%b table=%h pass=%b, want 1 2b 1", done_a, table_a, pass_a);
    end
    lag = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    int n_done = 0;
    expected_a = 8'h00;
    pulse_start_a();
    repeat (9) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || {in1_a, in2_a, in3_a} !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_stop: busy=%b in=%b%b%b, want 0 000", busy_a, in1_a, in2_a, in3_a);
    end
    for (int j = 0; j < 30; j++) begin
      if (done_a === 1'b1 || busy_a === 1'b1) n_done++;
      @(negedge clk);
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d active cycles after abort, want 0", n_done);
    end
    n_checks++;
    if (table_a !== 8'h2B || pass_a !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_hold: table=%h pass=%b, want 2b 1", table_a, pass_a);
    end
  endtask

  task automatic test_reset_mid();
    expected_a = 8'h2B;
    pulse_start_a();
    repeat (21) @(negedge clk);
    n_checks++;
    if ({in1_a, in2_a, in3_a} !== 3'd5) begin
      n_fail++;
      $display("FAIL rst_mid_row: in=%b%b%b, want 101", in1_a, in2_a, in3_a);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy_a, done_a, pass_a, in1_a, in2_a, in3_a} !== 6'b0 || table_a !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_async: busy=%b done=%b pass=%b in=%b%b%b table=%h, want all zero",
               busy_a, done_a, pass_a, in1_a, in2_a, in3_a, table_a);
    end
`ifdef TRUTH_TABLE_SWEEP_MISMATCH_EN
    n_checks++;
    if (mask_a !== 8'h00 || fbad_a !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_mask: mask=%h first_bad=%0d, want 00 0", mask_a, fbad_a);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start_a();
    for (int j = 1; j <= 32; j++) begin
      n_checks++;
      if (busy_a !== 1'b1 || {in1_a, in2_a, in3_a} !== 3'((j - 1) / 4)) begin
        n_fail++;
        $display("FAIL rst_resweep_row cycle %0d: busy=%b in=%b%b%b, want 1 %0d",
                 j, busy_a, in1_a, in2_a, in3_a, (j - 1) / 4);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done_a !== 1'b1 || table_a !== 8'h2B || pass_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_resweep_done: done=%b table=%h pass=%b, want 1 2b 1", done_a, table_a, pass_a);
    end
  endtask

  task automatic test_ignored_start();
    int n_busy = 0;
    int n_done = 0;
    repeat (3) @(negedge clk);
    pulse_start_a();
    for (int j = 1; j <= 45; j++) begin
      if (busy_a === 1'b1) n_busy++;
      if (done_a === 1'b1) n_done++;
      // Cycle 14 is inside row 3; cycle 33 is the FINISH cycle.
      start_a = (j == 14 || j == 33);
      @(negedge clk);
    end
    start_a = 1'b0;
    n_checks++;
    if (n_busy !== 32 || n_done !== 1) begin
      n_fail++;
      $display("FAIL ignored_start: busy cycles=%0d done pulses=%0d, want 32 1", n_busy, n_done);
    end
    n_checks++;
    if (busy_a !== 1'b0 || table_a !== 8'h2B) begin
      n_fail++;
      $display("FAIL ignored_start_idle: busy=%b table=%h, want 0 2b", busy_a, table_a);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_settle();
    test_abort();
    test_reset_mid();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
